// File: rtl/tx_uart.sv
// tx_uart: oversampled UART transmitter (16 baud ticks per bit).
// Serializes a byte as start bit, DBIT data bits LSB first, optional even
// parity bit, then SB_TICK ticks of stop level. Optional parity is enabled
// by defining the macro TX_UART_PARITY_EN.
//
// Parameters:
//   DBIT     data bits per frame (5..8)
//   SB_TICK  stop length in ticks (16 = 1, 24 = 1.5, 32 = 2 stop bits)
// Ports:
//   i_clock         system clock, rising edge
//   i_reset_n       synchronous active-low reset
//   i_tx_start      one-cycle transmit request, honoured only when idle
//   i_s_tick        baud tick, one clock wide, 16 per bit period
//   i_data          byte to send; bits [DBIT-1:0] used
//   o_tx            registered serial line, idles high
//   o_busy          high whenever a frame is in progress
//   o_tx_done_tick  one-clock pulse on the last tick of the stop period
module tx_uart #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_tx_start,
    input  logic       i_s_tick,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_tx_done_tick
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef TX_UART_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic [4:0]        tick_q, tick_d;
    logic [2:0]        bit_q, bit_d;
    logic [DBIT-1:0]   shift_q, shift_d;
    logic              tx_q, tx_d;
`ifdef TX_UART_PARITY_EN
    logic              parity_q, parity_d;
`endif

    // State register.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q  <= StIdle;
            tick_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef TX_UART_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef TX_UART_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state logic; all advancement outside idle is gated by the tick.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
`ifdef TX_UART_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (i_tx_start) begin
                    shift_d  = i_data[DBIT-1:0];
                    tick_d   = '0;
                    state_d  = StStart;
`ifdef TX_UART_PARITY_EN
                    parity_d = ^i_data[DBIT-1:0];
`endif
                end
            end
            StStart: begin
                if (i_s_tick) begin
                    if (tick_q == 5'd15) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = StData;
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end
            StData: begin
                if (i_s_tick) begin
                    if (tick_q == 5'd15) begin
                        tick_d  = '0;
                        shift_d = shift_q >> 1;
                        if (bit_q == 3'(DBIT - 1)) begin
`ifdef TX_UART_PARITY_EN
                            state_d = StParity;
`else
                            state_d = StStop;
`endif
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end
`ifdef TX_UART_PARITY_EN
            StParity: begin
                if (i_s_tick) begin
                    if (tick_q == 5'd15) begin
                        tick_d  = '0;
                        state_d = StStop;
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end
`endif
            StStop: begin
                if (i_s_tick) begin
                    if (tick_q == 5'(SB_TICK - 1)) begin
                        tick_d  = '0;
                        state_d = StIdle;
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level for the coming state, so o_tx changes on the same edge
        // as the state and stays a pure flop output.
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
`ifdef TX_UART_PARITY_EN
            StParity: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    // Outputs. Done is suppressed on a reset edge so an aborted frame
    // never reports completion.
    always_comb begin
        o_tx           = tx_q;
        o_busy         = (state_q != StIdle);
        o_tx_done_tick = i_reset_n && i_s_tick && (state_q == StStop) &&
                         (tick_q == 5'(SB_TICK - 1));
    end

endmodule

// File: tb/tb_tx_uart.sv
// tb_tx_uart: randomized self-checking bench for tx_uart.
// Drives two instances (SB_TICK = 16 and 32) with the same stimulus and
// compares each against a tick-count reference model of the frame.
// Honours TX_UART_PARITY_EN the same way as the design.
module tb_tx_uart;

    localparam int DBIT = 8;
`ifdef TX_UART_PARITY_EN
    localparam int PAR = 16;
`else
    localparam int PAR = 0;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic       tx_start;
    logic       s_tick;
    logic [7:0] data;
    logic       obs_tx   [2];
    logic       obs_busy [2];
    logic       obs_done [2];

    always #5 clock = ~clock;

    tx_uart #(.DBIT(DBIT), .SB_TICK(16)) dut0 (
        .i_clock        (clock),
        .i_reset_n      (reset_n),
        .i_tx_start     (tx_start),
        .i_s_tick       (s_tick),
        .i_data         (data),
        .o_tx           (obs_tx[0]),
        .o_busy         (obs_busy[0]),
        .o_tx_done_tick (obs_done[0])
    );

    tx_uart #(.DBIT(DBIT), .SB_TICK(32)) dut1 (
        .i_clock        (clock),
        .i_reset_n      (reset_n),
        .i_tx_start     (tx_start),
        .i_s_tick       (s_tick),
        .i_data         (data),
        .o_tx           (obs_tx[1]),
        .o_busy         (obs_busy[1]),
        .o_tx_done_tick (obs_done[1])
    );

    int tests = 0;
    int fails = 0;

    // Reference model: a frame is a count of ticks since acceptance.
    logic       mdl_busy [2];
    int         mdl_k    [2];
    logic [7:0] mdl_data [2];
    int         done_cnt [2];
    int         tcount   [2];
    int         cyc = 0;
    bit         tick_rand = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sb_of(input int i);
        return (i == 0) ? 16 : 32;
    endfunction

    function automatic int frame_len(input int i);
        return 16 * (1 + DBIT) + PAR + sb_of(i);
    endfunction

    function automatic logic exp_level(input int i);
        int k;
        logic [7:0] d;
        k = mdl_k[i];
        d = mdl_data[i];
        if (k < 16) return 1'b0;
        if (k < 16 * (1 + DBIT)) return d[(k / 16) - 1];
        if (k < 16 * (1 + DBIT) + PAR) return ^d[DBIT-1:0];
        return 1'b1;
    endfunction

    // One clock: check at the negedge, update model at the posedge, then
    // drive the next cycle's inputs.
    task automatic step();
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("tx%0d", i), 32'(obs_tx[i]),
                  32'(mdl_busy[i] ? exp_level(i) : 1'b1));
            check($sformatf("busy%0d", i), 32'(obs_busy[i]), 32'(mdl_busy[i]));
            check($sformatf("done%0d", i), 32'(obs_done[i]),
                  32'(mdl_busy[i] && s_tick && reset_n && (mdl_k[i] == frame_len(i) - 1)));
            if (obs_busy[i] === 1'b1 && s_tick) tcount[i]++;
            if (obs_done[i] === 1'b1) begin
                done_cnt[i]++;
                check($sformatf("frame_ticks%0d", i), 32'(tcount[i]), 32'(frame_len(i)));
            end
            if (obs_busy[i] !== 1'b1) tcount[i] = 0;
        end
        @(posedge clock);
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                mdl_busy[i] = 1'b0;
                mdl_k[i]    = 0;
            end else if (mdl_busy[i]) begin
                if (s_tick) begin
                    if (mdl_k[i] == frame_len(i) - 1) mdl_busy[i] = 1'b0;
                    else mdl_k[i]++;
                end
            end else if (tx_start) begin
                mdl_busy[i] = 1'b1;
                mdl_k[i]    = 0;
                mdl_data[i] = data;
            end
        end
        #1;
        cyc++;
        tx_start = 1'b0;
        s_tick   = tick_rand ? ($urandom_range(0, 2) == 0) : ((cyc % 4) == 0);
    endtask

    task automatic send(input logic [7:0] b);
        data     = b;
        tx_start = 1'b1;
        step();
    endtask

    task automatic run_until_idle(input int limit);
        int n;
        n = 0;
        while ((mdl_busy[0] || mdl_busy[1]) && n < limit) begin
            step();
            n++;
        end
        check("idle_timeout", 32'(n >= limit), 32'd0);
    endtask

    int d0, d1, n;

    initial begin
        for (int i = 0; i < 2; i++) begin
            mdl_busy[i] = 1'b0;
            mdl_k[i]    = 0;
            mdl_data[i] = '0;
            done_cnt[i] = 0;
            tcount[i]   = 0;
        end
        reset_n  = 1'b0;
        tx_start = 1'b0;
        s_tick   = 1'b0;
        data     = '0;
        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_tx%0d", i), 32'(obs_tx[i]), 32'd1);
            check($sformatf("reset_busy%0d", i), 32'(obs_busy[i]), 32'd0);
        end
        reset_n = 1'b1;

        // Idle with ticks every 4 clocks: line high, no done.
        repeat (40) step();
        check("idle_no_done", 32'(done_cnt[0] + done_cnt[1]), 32'd0);

        // Single frame 0xA5.
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        send(8'hA5);
        run_until_idle(3000);
        check("a5_done0", 32'(done_cnt[0] - d0), 32'd1);
        check("a5_done1", 32'(done_cnt[1] - d1), 32'd1);

        // 0x3C with a stray 0xFF strobe mid-frame, then 0xFF right after done.
        d0 = done_cnt[0];
        send(8'h3C);
        repeat (200) step();
        send(8'hFF);
        data = 8'h81;
        n = 0;
        while (done_cnt[0] == d0 && n < 3000) begin
            step();
            n++;
        end
        check("3c_done_timeout", 32'(n >= 3000), 32'd0);
        check("3c_single_done", 32'(done_cnt[0] - d0), 32'd1);
        send(8'hFF);
        check("b2b_start_bit", 32'(obs_tx[0]), 32'd0);
        check("b2b_busy", 32'(obs_busy[0]), 32'd1);
        run_until_idle(3000);

        // Reset during data bit 3 of 0x55.
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        send(8'h55);
        n = 0;
        while (mdl_k[0] < 16 * 4 + 8 && n < 1000) begin
            step();
            n++;
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("abort_tx%0d", i), 32'(obs_tx[i]), 32'd1);
            check($sformatf("abort_busy%0d", i), 32'(obs_busy[i]), 32'd0);
        end
        check("abort_no_done0", 32'(done_cnt[0] - d0), 32'd0);
        check("abort_no_done1", 32'(done_cnt[1] - d1), 32'd0);
        repeat (5) step();
        send(8'h96);
        run_until_idle(3000);

        // Parity reference frames (plain frames when parity is disabled).
        send(8'h07);
        run_until_idle(3000);
        send(8'h03);
        run_until_idle(3000);

        // Random ticks, random data churn and stray strobes.
        tick_rand = 1;
        for (int f = 0; f < 6; f++) begin
            send(8'($urandom));
            n = $urandom_range(50, 900);
            for (int c = 0; c < n; c++) begin
                data = 8'($urandom);
                if ($urandom_range(0, 99) == 0) tx_start = 1'b1;
                step();
            end
            run_until_idle(5000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tx_uart.md
Name: tx_uart

Overview:
- UART serial transmitter. It is the transmit counterpart of the team's oversampled UART receiver and shares the same baud-rate tick generator (16 ticks per bit).
- Accepts a parallel byte on a single-cycle start strobe and serializes it as start bit, DBIT data bits LSB first, then stop bit(s).
- Signals completion with a one-cycle done pulse.
- Sits between the interface/control FSM and the TX pin.

Parameters:
- DBIT, 8, number of data bits per frame; legal range 5..8.
- SB_TICK, 16, stop-bit length in ticks; 16 = 1 stop bit, 24 = 1.5, 32 = 2; legal range 16..32.

Ports:
- i_clock  input  1  system clock; all logic on rising edge.
- i_reset_n  input  1  synchronous, active-low reset.
- i_tx_start  input  1  single-cycle request to transmit i_data; honoured only in IDLE.
- i_s_tick  input  1  baud tick, 16 per bit period, one clock wide.
- i_data  input  8  byte to send; bits [DBIT-1:0] used, upper bits ignored.
- o_tx  output  1  serial line, registered, idles high.
- o_busy  output  1  high whenever state != IDLE.
- o_tx_done_tick  output  1  one-clock pulse at end of stop period.

Behaviour:
- Reset (i_reset_n low at a clock edge):
  - state = IDLE; tick counter = 0; bit counter = 0; shift register = 0.
  - o_tx = 1, o_busy = 0, o_tx_done_tick = 0.
- Tick counter is 5 bits wide (covers SB_TICK up to 32). Bit counter is 3 bits wide.
- IDLE:
  - o_tx = 1.
  - On i_tx_start = 1: capture i_data[DBIT-1:0] into the shift register, clear the tick counter, go to START.
  - o_tx falls to 0 on the same edge, so the start bit appears the clock after the strobe.
- START:
  - o_tx = 0.
  - Each i_s_tick increments the tick counter.
  - On the tick where counter == 15: clear counter, clear bit counter, go to DATA.
  - Start bit therefore lasts exactly 16 ticks.
- DATA:
  - o_tx = shift register bit 0.
  - On the tick where counter == 15: clear counter and shift the register right by one.
  - If bit counter == DBIT-1, go to the next state (PARITY if enabled, else STOP); otherwise increment the bit counter.
  - Each data bit lasts exactly 16 ticks.
- STOP:
  - o_tx = 1.
  - On the tick where counter == SB_TICK-1: go to IDLE and assert o_tx_done_tick for exactly that one clock.
- Ticks drive all advancement: with no i_s_tick, every state and counter holds and o_tx is stable.
- i_tx_start outside IDLE is ignored. Neither the data nor the frame is altered, including when the strobe coincides with the done pulse.
  - Back-to-back frames: the next strobe is accepted at the earliest the clock after o_tx_done_tick. The line stays high for at least one clock between frames.
- i_data is sampled only on the accepting edge; later changes have no effect on the frame in flight.
- Reset mid-frame: the frame is aborted, o_tx returns high on the reset edge, and no done pulse is produced.
- o_tx is driven from a flop. The output is glitch-free; there is no combinational path from any input to o_tx.
- Frame length, no parity: 16*(1+DBIT) + SB_TICK ticks. Default 160 ticks.

Optional Feature:
- Macro: TX_UART_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - Parity bit = XOR of the DBIT data bits (even parity), computed at capture time.
  - o_tx = parity bit for 16 ticks, then STOP.
  - Frame length grows by 16 ticks.
- Undefined: DATA goes straight to STOP; no parity logic is present.

Test Plan:
- Reset, then idle with i_s_tick every 4 clocks -> o_tx = 1, o_busy = 0, o_tx_done_tick never asserts.
- Strobe i_data = 8'hA5, tick every 4 clocks -> o_tx low for 64 clocks, then bits 1,0,1,0,0,1,0,1 at 64 clocks each, then high.
  - o_tx_done_tick pulses once, 640 clocks after the start bit begins; o_busy high throughout.
- Strobe 8'h3C, then strobe 8'hFF mid-frame -> the line carries 8'h3C only (bits 0,0,1,1,1,1,0,0) and a single done pulse.
  - Then strobe 8'hFF the clock after done -> the second frame starts one clock later.
- SB_TICK = 32, send 8'h00 -> stop period high for 32 ticks; total frame 176 ticks.
- Assert i_reset_n low during data bit 3 of 8'h55 -> o_tx = 1 and o_busy = 0 next clock, no done pulse.
  - A new strobe after reset sends a clean frame.
- With TX_UART_PARITY_EN, send 8'h07 then 8'h03:
  - Parity bit is 1 for 8'h07 and 0 for 8'h03, each lasting 16 ticks.
  - Frame length is 176 ticks.
